// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcode encodings, FSM state type and opcode legality check.
package alu_seq_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_SLL   = 4'b1110;
   localparam logic [3:0] ALU_SRL   = 4'b1111;
   localparam logic [3:0] ALU_MULTU = 4'b1000;
   localparam logic [3:0] ALU_DIVU  = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // MULTU/DIVU are only legal when the iterative unit is built.
   function automatic logic alu_is_illegal(input logic [3:0] op, input logic muldiv_en);
      logic r;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL: r = 1'b0;
         ALU_MULTU, ALU_DIVU:               r = ~muldiv_en;
         default:                           r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath, one step per cycle.
// o_next_* present the accumulator value after the current step so the caller can register it.
module alu_iter_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_next_lo,
   output logic [WIDTH-1:0] o_next_hi,
   output logic             o_last
);

   logic             r_mode;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [SHW-1:0]   r_cnt;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_next_hi;
   logic [WIDTH-1:0] w_next_lo;

   // Multiply: {hi,lo} shifts right with lo holding the multiplier.
   // Divide: {rem,quot} shifts left with lo holding the dividend; diff MSB is the borrow.
   always_comb begin
      w_sum     = {1'b0, r_hi} + {1'b0, r_b};
      w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
      w_diff    = w_rem_sh - {1'b0, r_b};
      w_next_hi = r_hi;
      w_next_lo = r_lo;
      if (!r_mode) begin
         if (r_lo[0]) {w_next_hi, w_next_lo} = {w_sum, r_lo[WIDTH-1:1]};
         else         {w_next_hi, w_next_lo} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
      end else begin
         if (!w_diff[WIDTH]) begin
            w_next_hi = w_diff[WIDTH-1:0];
            w_next_lo = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_next_hi = w_rem_sh[WIDTH-1:0];
            w_next_lo = {r_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_mode <= i_mode;
         r_hi   <= '0;
         r_lo   <= i_a;
         r_b    <= i_b;
         r_cnt  <= SHW'(WIDTH - 1);
      end else if (i_step) begin
         r_hi   <= w_next_hi;
         r_lo   <= w_next_lo;
         r_cnt  <= r_cnt - SHW'(1);
      end
   end

   assign o_next_lo = w_next_lo;
   assign o_next_hi = w_next_hi;
   assign o_last    = (r_cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU with valid/ready front end, registered outputs and optional iterative MULTU/DIVU.
// The iterative path and ITER/DONE states exist only when ALU_SEQ_MULDIV_EN is defined.
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here with out_valid next cycle
// ITER  | multiply/divide stepping, in_ready low
// DONE  | iterative result presented (out_valid), ready for a new request
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             fault
);

`ifdef ALU_SEQ_MULDIV_EN
   localparam logic MULDIV_EN = 1'b1;
`else
   localparam logic MULDIV_EN = 1'b0;
`endif

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi;
   logic             r_zero;
   logic             r_fault;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_start;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_hi;
   logic             w_zero;
   logic             w_fault;

   always_comb begin
      w_res   = '0;
      w_hi    = '0;
      w_zero  = 1'b0;
      w_fault = 1'b0;
      w_diff  = rs - rt;
      case (alu_control)
         ALU_AND: w_res = rs & rt;
         ALU_OR:  w_res = rs | rt;
         ALU_ADD: w_res = rs + rt;
         ALU_SUB: begin
            w_res  = w_diff;
            w_zero = (w_diff == '0);
         end
         ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
         ALU_NOR: w_res = ~(rs | rt);
         ALU_SLL: w_res = rt << shamt;
         ALU_SRL: w_res = rt >> shamt;
`ifdef ALU_SEQ_MULDIV_EN
         ALU_DIVU: begin
            if (rt == '0) begin
               w_res   = '1;
               w_hi    = rs;
               w_fault = 1'b1;
            end
         end
`endif
         default: ;
      endcase
      if (alu_is_illegal(alu_control, MULDIV_EN)) w_fault = 1'b1;
   end

   assign w_accept = in_valid & w_in_ready;

`ifdef ALU_SEQ_MULDIV_EN
   alu_state_t       r_state;
   alu_state_t       w_state_next;
   logic             w_is_iter;
   logic [WIDTH-1:0] w_iter_lo;
   logic [WIDTH-1:0] w_iter_hi;
   logic             w_iter_last;
   logic             w_iter_done;

   assign w_in_ready  = (r_state != ITER);
   assign w_is_iter   = (alu_control == ALU_MULTU) ||
                        ((alu_control == ALU_DIVU) && (rt != '0));
   assign w_start     = w_accept & w_is_iter;
   assign w_iter_done = (r_state == ITER) & w_iter_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: w_state_next = w_start ? ITER : IDLE;
         ITER:       if (w_iter_last) w_state_next = DONE;
         default:    w_state_next = IDLE;
      endcase
   end

   alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_start),
      .i_step    (r_state == ITER),
      .i_mode    (alu_control == ALU_DIVU),
      .i_a       (rs),
      .i_b       (rt),
      .o_next_lo (w_iter_lo),
      .o_next_hi (w_iter_hi),
      .o_last    (w_iter_last)
   );
`else
   assign w_in_ready = 1'b1;
   assign w_start    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_hi        <= '0;
         r_zero      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_accept && !w_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_hi        <= w_hi;
            r_zero      <= w_zero;
            r_fault     <= w_fault;
         end
`ifdef ALU_SEQ_MULDIV_EN
         // Final step lands straight in the output registers so out_valid rises in DONE.
         else if (w_iter_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_iter_lo;
            r_hi        <= w_iter_hi;
            r_zero      <= 1'b0;
            r_fault     <= 1'b0;
         end
`endif
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign hi        = r_hi;
   assign zero      = r_zero;
   assign fault     = r_fault;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected responses, a monitor pops on out_valid.
module tb_alu_seq;
   localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   alu_control = 4'b0;
   logic [W-1:0] rs = '0;
   logic [W-1:0] rt = '0;
   logic [4:0]   shamt = '0;
   logic         out_valid;
   logic [W-1:0] result;
   logic [W-1:0] hi;
   logic         zero;
   logic         fault;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .rs(rs), .rt(rt), .shamt(shamt),
      .out_valid(out_valid), .result(result), .hi(hi), .zero(zero), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         zero;
      logic         fault;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t mk(logic [W-1:0] r, logic [W-1:0] h, logic z, logic f);
      exp_t e;
      e.res = r; e.hi = h; e.zero = z; e.fault = f;
      return e;
   endfunction

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out_valid: got result=%h hi=%h, expected no response", result, hi);
         end else begin
            mon_e = q.pop_front();
            if (result !== mon_e.res || hi !== mon_e.hi || zero !== mon_e.zero || fault !== mon_e.fault) begin
               n_fail++;
               $display("FAIL response: got res=%h hi=%h z=%b f=%b, expected res=%h hi=%h z=%b f=%b",
                        result, hi, zero, fault, mon_e.res, mon_e.hi, mon_e.zero, mon_e.fault);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic send(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [4:0] sh,
                       exp_t e, bit expect_out);
      int n;
      alu_control = op; rs = a; rt = b; shamt = sh; in_valid = 1'b1;
      if (expect_out) q.push_back(e);
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic count_busy(string name, int req);
      int cnt;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check(name, cnt, req);
      check({name, "_out_valid"}, out_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_hi", hi, 0);
      check("rst_zero", zero, 0);
      check("rst_fault", fault, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, mk(32'h8000_0000, 0, 0, 0), 1);
      check("add_latency", out_valid, 1);

      send(4'b0110, 32'h1234, 32'h1234, 0, mk(0, 0, 1, 0), 1);
      check("sub_b2b_valid", out_valid, 1);
      send(4'b0111, 32'hFFFF_FFFF, 32'h1, 0, mk(1, 0, 0, 0), 1);
      check("slt_b2b_valid", out_valid, 1);
      send(4'b0110, 32'h5, 32'h7, 0, mk(32'hFFFF_FFFE, 0, 0, 0), 1);
      send(4'b0111, 32'h1, 32'hFFFF_FFFF, 0, mk(0, 0, 0, 0), 1);

      send(4'b1111, 0, 32'h8000_0000, 31, mk(1, 0, 0, 0), 1);
      send(4'b1110, 0, 32'h3, 4, mk(32'h30, 0, 0, 0), 1);
      send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, mk(32'h00F0_1200, 0, 0, 0), 1);
      send(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 0, mk(32'hFFF0_FF34, 0, 0, 0), 1);
      send(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 0, mk(32'h000F_00CB, 0, 0, 0), 1);
      send(4'b0101, 32'h55, 32'hAA, 0, mk(0, 0, 0, 1), 1);

      send(4'b1000, 32'hFFFF_FFFF, 32'h2, 0,
           MD ? mk(32'hFFFF_FFFE, 32'h1, 0, 0) : mk(0, 0, 0, 1), 1);
      count_busy("multu_busy", MD ? W : 0);

      send(4'b1000, 32'h1234_5678, 32'h100, 0,
           MD ? mk(32'h3456_7800, 32'h12, 0, 0) : mk(0, 0, 0, 1), 1);
      send(4'b0010, 32'h10, 32'h20, 0, mk(32'h30, 0, 0, 0), 1);
      check("held_add_valid", out_valid, 1);

      send(4'b1001, 32'd100, 32'd7, 0, MD ? mk(32'd14, 32'd2, 0, 0) : mk(0, 0, 0, 1), 1);
      count_busy("divu_busy", MD ? W : 0);
      send(4'b1001, 32'hFFFF_FFFF, 32'h10, 0,
           MD ? mk(32'h0FFF_FFFF, 32'hF, 0, 0) : mk(0, 0, 0, 1), 1);
      count_busy("divu2_busy", MD ? W : 0);
      send(4'b1001, 32'd100, 32'd0, 0, MD ? mk(32'hFFFF_FFFF, 32'd100, 0, 1) : mk(0, 0, 0, 1), 1);
      check("div0_latency", out_valid, 1);

      send(4'b0010, 32'h1111_0000, 32'h0000_2222, 0, mk(32'h1111_2222, 0, 0, 0), 1);
      send(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
           MD ? mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0) : mk(0, 0, 0, 1), !MD);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_result", result, 0);
      check("abort_hi", hi, 0);
      check("abort_fault", fault, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_idle_ready", in_ready, 1);

      send(4'b0010, 32'h1, 32'h2, 0, mk(32'h3, 0, 0, 0), 1);
      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
